// File: rtl/mac_fp_pkg.sv
// Shared definitions for the floating-point MAC drain: data width, pipeline latency
// and IEEE field classification helpers used by the optional exception flags.
package mac_fp_pkg;

   localparam int SIG_WIDTH = 23;
   localparam int EXP_WIDTH = 8;
   localparam int DATA_W    = EXP_WIDTH + SIG_WIDTH + 1;

   localparam int EXC_NAN_BIT = 0;
   localparam int EXC_INF_BIT = 1;
   localparam int EXC_W       = 2;

   // Field helpers take a wide zero-extended field plus its real width.
   localparam int FIELD_MAX = 64;

   function automatic int pipe_latency(input int mult_latency, input int add_latency);
      return mult_latency + 1 + add_latency;
   endfunction

   function automatic logic exp_all_ones(input logic [FIELD_MAX-1:0] e, input int ew);
      logic [FIELD_MAX-1:0] mask;
      mask = (FIELD_MAX'(1) << ew) - FIELD_MAX'(1);
      return (e & mask) == mask;
   endfunction

   function automatic logic mant_zero(input logic [FIELD_MAX-1:0] m, input int sw);
      logic [FIELD_MAX-1:0] mask;
      mask = (FIELD_MAX'(1) << sw) - FIELD_MAX'(1);
      return (m & mask) == {FIELD_MAX{1'b0}};
   endfunction

endpackage

// File: rtl/data_shift_reg.sv
// Generic enabled shift register with synchronous clear; q is the oldest stage.
module data_shift_reg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift chain; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
      end else if (en) begin
         stage_r[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
      end
   end

   assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/mac_drain_fifo.sv
// First-word-fall-through FIFO; head data reads as zero when empty.
module mac_drain_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             do_wr_s, do_rd_s;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_rd_s = rd_en && !empty;
   // A pop in the same cycle frees the slot, so a write when full is still accepted.
   assign do_wr_s = wr_en && (!full || do_rd_s);

   // Pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (do_wr_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (do_rd_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (do_wr_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
   end

   // Head entry, masked to zero when empty.
   always_comb begin
      rd_data = {WIDTH{1'b0}};
      if (empty) begin
         rd_data = {WIDTH{1'b0}};
      end else begin
         rd_data = mem_r[rd_ptr_r[AW-1:0]];
      end
   end

endmodule

// File: rtl/mac_fp_drain.sv
// Credit-based drain for the FP MAC: tracks issues through the MAC latency and buffers z.
// Optional sticky NaN/infinity flags when MAC_FP_DRAIN_EXC_FLAG_EN is defined.
module mac_fp_drain
   import mac_fp_pkg::*;
#(
   parameter int sig_width    = SIG_WIDTH,
   parameter int exp_width    = EXP_WIDTH,
   parameter int MULT_LATENCY = 1,
   parameter int ADD_LATENCY  = 11,
   parameter int TAG_WIDTH    = 8,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   output logic                         issue_ready,
   input  logic [TAG_WIDTH-1:0]         issue_tag,
   input  logic [exp_width+sig_width:0] mac_z,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [exp_width+sig_width:0] m_data,
   output logic [TAG_WIDTH-1:0]         m_tag,
   output logic [$clog2(FIFO_DEPTH):0]  credit_cnt,
   output logic                         err_overflow
`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
   ,
   output logic [EXC_W-1:0]             exc_flags,
   input  logic                         exc_clr
`endif
);

   localparam int DW           = exp_width + sig_width + 1;
   localparam int PIPE_LATENCY = pipe_latency(MULT_LATENCY, ADD_LATENCY);
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam int FW           = TAG_WIDTH + DW;

   logic                 issue_fire_s, pop_s;
   logic [TAG_WIDTH:0]   dl_d_s, dl_q_s;
   logic                 wr_en_s, overflow_s;
   logic [FW-1:0]        wr_data_s, rd_data_s;
   logic                 fifo_full_s, fifo_empty_s;
   logic [CNT_W-1:0]     credit_r;
   logic                 err_r;

   assign issue_ready  = !rst && (credit_r != {CNT_W{1'b0}});
   assign issue_fire_s = issue_valid && issue_ready;
   assign pop_s        = !fifo_empty_s && m_ready;

   assign dl_d_s = {issue_fire_s, issue_tag};

   data_shift_reg #(
      .WIDTH (TAG_WIDTH + 1),
      .DEPTH (PIPE_LATENCY)
   ) u_delay (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (dl_d_s),
      .q   (dl_q_s)
   );

   assign wr_en_s    = dl_q_s[TAG_WIDTH];
   assign wr_data_s  = {dl_q_s[TAG_WIDTH-1:0], mac_z};
   assign overflow_s = wr_en_s && fifo_full_s && !pop_s;

   mac_drain_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en_s),
      .wr_data (wr_data_s),
      .rd_en   (m_ready),
      .rd_data (rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   assign m_valid    = !fifo_empty_s;
   assign m_data     = rd_data_s[DW-1:0];
   assign m_tag      = rd_data_s[FW-1:DW];
   assign credit_cnt = credit_r;

   // Credit counter: issue consumes, pop returns, both together cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_r <= CNT_W'(FIFO_DEPTH);
      end else begin
         case ({issue_fire_s, pop_s})
            2'b10:   credit_r <= credit_r - CNT_W'(1);
            2'b01:   credit_r <= credit_r + CNT_W'(1);
            default: credit_r <= credit_r;
         endcase
      end
   end

   // Sticky overflow error, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (overflow_s) begin
         err_r <= 1'b1;
      end
   end

   assign err_overflow = err_r;

`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
   logic [EXC_W-1:0] exc_new_s, exc_r;
   logic [FIELD_MAX-1:0] exp_field_s, mant_field_s;

   assign exp_field_s  = FIELD_MAX'(mac_z[DW-2 -: exp_width]);
   assign mant_field_s = FIELD_MAX'(mac_z[sig_width-1:0]);

   // Classify each accepted FIFO write.
   always_comb begin
      exc_new_s = {EXC_W{1'b0}};
      if (wr_en_s && !overflow_s) begin
         if (exp_all_ones(exp_field_s, exp_width)) begin
            if (mant_zero(mant_field_s, sig_width)) begin
               exc_new_s[EXC_INF_BIT] = 1'b1;
            end else begin
               exc_new_s[EXC_NAN_BIT] = 1'b1;
            end
         end else begin
            exc_new_s = {EXC_W{1'b0}};
         end
      end else begin
         exc_new_s = {EXC_W{1'b0}};
      end
   end

   // Sticky flags; a new exception wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         exc_r <= {EXC_W{1'b0}};
      end else if (exc_clr) begin
         exc_r <= exc_new_s;
      end else begin
         exc_r <= exc_r | exc_new_s;
      end
   end

   assign exc_flags = exc_r;
`endif

endmodule

// File: tb/tb_mac_fp_drain.sv
// Directed testbench for mac_fp_drain with a 13-cycle behavioural MAC model.
module tb_mac_fp_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic [7:0]  issue_tag;
   logic [31:0] mac_z;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [7:0]  m_tag;
   logic [4:0]  credit_cnt;
   logic        err_overflow;
`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
   logic [1:0]  exc_flags;
   logic        exc_clr;
`endif

   logic [31:0] z_in;
   logic [31:0] mpipe [13];
   int          cyc = 0;
   int          nvec = 0;
   int          nerr = 0;
   int          fires, rx, bubbles, minc, seen;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // MAC model: result appears on mac_z 13 cycles after the issuing cycle.
   always @(posedge clk) begin
      for (int i = 12; i > 0; i--) mpipe[i] <= mpipe[i-1];
      mpipe[0] <= (issue_valid && issue_ready) ? z_in : 32'h0;
   end
   assign mac_z = mpipe[12];

   mac_fp_drain dut (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (issue_valid),
      .issue_ready  (issue_ready),
      .issue_tag    (issue_tag),
      .mac_z        (mac_z),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_tag        (m_tag),
      .credit_cnt   (credit_cnt),
      .err_overflow (err_overflow)
`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
      ,
      .exc_flags    (exc_flags),
      .exc_clr      (exc_clr)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] zval(input logic [7:0] t);
      return 32'h3F80_0000 | {24'h0, t};
   endfunction

   initial begin
      rst = 1'b1; issue_valid = 1'b0; m_ready = 1'b0; issue_tag = 8'h0; z_in = 32'h0;
`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
      exc_clr = 1'b0;
`endif
      tick(); tick();
      chk("rst_issue_ready", 64'(issue_ready), 64'd0);
      chk("rst_credit", 64'(credit_cnt), 64'd16);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_m_data", 64'(m_data), 64'd0);
      chk("rst_m_tag", 64'(m_tag), 64'd0);
      chk("rst_err", 64'(err_overflow), 64'd0);
      rst = 1'b0;
      while (cyc < 10) tick();

      // Single op issued at cycle 10, visible at cycle 24.
      issue_valid = 1'b1; issue_tag = 8'h5A; z_in = 32'h40E0_0000;
      chk("single_ready", 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0;
      chk("single_credit_dec", 64'(credit_cnt), 64'd15);
      while (cyc < 23) tick();
      chk("single_not_yet", 64'(m_valid), 64'd0);
      tick();
      chk("single_valid_c24", 64'(m_valid), 64'd1);
      chk("single_data", 64'(m_data), 64'h40E0_0000);
      chk("single_tag", 64'(m_tag), 64'h5A);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk("single_credit_ret", 64'(credit_cnt), 64'd16);
      chk("single_empty", 64'(m_valid), 64'd0);

      // Backpressure fill.
      issue_valid = 1'b1; fires = 0;
      for (int i = 0; i < 30; i++) begin
         issue_tag = fires[7:0]; z_in = zval(fires[7:0]);
         if (issue_ready) fires++;
         tick();
      end
      issue_valid = 1'b0;
      tick(); tick(); tick();
      chk("fill_fires", 64'(fires), 64'd16);
      chk("fill_ready_low", 64'(issue_ready), 64'd0);
      chk("fill_credit", 64'(credit_cnt), 64'd0);
      chk("fill_valid", 64'(m_valid), 64'd1);
      chk("fill_no_overflow", 64'(err_overflow), 64'd0);
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("fill_drain_valid", 64'(m_valid), 64'd1);
         chk("fill_drain_tag", 64'(m_tag), 64'(i));
         chk("fill_drain_data", 64'(m_data), 64'(zval(8'(i))));
         tick();
      end
      chk("fill_drained", 64'(m_valid), 64'd0);
      chk("fill_credit_back", 64'(credit_cnt), 64'd16);

      // Streaming 100 ops with downstream always ready.
      fires = 0; rx = 0; bubbles = 0; minc = 16;
      for (int i = 0; i < 200 && rx < 100; i++) begin
         issue_valid = (fires < 100);
         issue_tag = fires[7:0]; z_in = zval(fires[7:0]);
         if (int'(credit_cnt) < minc) minc = int'(credit_cnt);
         if (m_valid) begin
            chk("stream_tag", 64'(m_tag), 64'(rx));
            chk("stream_data", 64'(m_data), 64'(zval(rx[7:0])));
            rx++;
         end else if (rx > 0) begin
            bubbles++;
         end
         if (issue_valid && issue_ready) fires++;
         tick();
      end
      issue_valid = 1'b0;
      chk("stream_fires", 64'(fires), 64'd100);
      chk("stream_results", 64'(rx), 64'd100);
      chk("stream_bubbles", 64'(bubbles), 64'd0);
      // 13 ops in the delay line plus the head entry awaiting its pop.
      chk("stream_min_credit", 64'(minc), 64'd2);
      tick(); tick();
      chk("stream_credit_back", 64'(credit_cnt), 64'd16);

      // Mid-operation reset: 3 in FIFO, 5 in flight.
      m_ready = 1'b0; issue_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         issue_tag = 8'(8'h80 + k); z_in = 32'hDEAD_0000 | 32'(k);
         tick();
      end
      issue_valid = 1'b0;
      repeat (8) tick();
      chk("mrst_credit_pre", 64'(credit_cnt), 64'd8);
      chk("mrst_valid_pre", 64'(m_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mrst_ready_low", 64'(issue_ready), 64'd0);
      tick();
      rst = 1'b0;
      chk("mrst_m_valid", 64'(m_valid), 64'd0);
      chk("mrst_credit", 64'(credit_cnt), 64'd16);
      chk("mrst_m_data", 64'(m_data), 64'd0);
      m_ready = 1'b1; seen = 0;
      repeat (20) begin
         if (m_valid) seen++;
         tick();
      end
      chk("mrst_no_stale", 64'(seen), 64'd0);
      chk("mrst_credit_after", 64'(credit_cnt), 64'd16);

      // Issue and pop together with one credit left.
      m_ready = 1'b0; issue_valid = 1'b1;
      for (int k = 0; k < 15; k++) begin
         issue_tag = 8'(k); z_in = zval(8'(k));
         tick();
      end
      issue_valid = 1'b0;
      repeat (16) tick();
      chk("edge_credit_one", 64'(credit_cnt), 64'd1);
      chk("edge_valid", 64'(m_valid), 64'd1);
      issue_valid = 1'b1; m_ready = 1'b1; issue_tag = 8'hEE; z_in = zval(8'hEE);
      chk("edge_ready_pre", 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0;
      chk("edge_credit_hold", 64'(credit_cnt), 64'd1);
      chk("edge_ready_hold", 64'(issue_ready), 64'd1);
      repeat (40) tick();
      chk("edge_credit_back", 64'(credit_cnt), 64'd16);
      chk("edge_no_overflow", 64'(err_overflow), 64'd0);

`ifdef MAC_FP_DRAIN_EXC_FLAG_EN
      // Exception flags.
      m_ready = 1'b1;
      chk("exc_initial", 64'(exc_flags), 64'd0);
      issue_valid = 1'b1; issue_tag = 8'h01; z_in = 32'h7FC0_0000;
      tick();
      issue_valid = 1'b0;
      repeat (15) tick();
      chk("exc_nan", 64'(exc_flags), 64'b01);
      issue_valid = 1'b1; issue_tag = 8'h02; z_in = 32'h7F80_0000;
      tick();
      issue_valid = 1'b0;
      repeat (15) tick();
      chk("exc_nan_inf", 64'(exc_flags), 64'b11);
      exc_clr = 1'b1;
      tick();
      exc_clr = 1'b0;
      chk("exc_clr", 64'(exc_flags), 64'b00);
      issue_valid = 1'b1; issue_tag = 8'h03; z_in = 32'h7FC0_0001;
      tick();
      issue_valid = 1'b0;
      repeat (12) tick();
      exc_clr = 1'b1;
      tick();
      exc_clr = 1'b0;
      chk("exc_clr_vs_nan", 64'(exc_flags), 64'b01);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
